// File: rtl/triangle_wave_analyzer_pkg.sv
// Shared definitions for the triangle wave analyzer.
// Step classification encodings, analyzer FSM states and the error counter width.
// Imported by the analyzer top and its saturating counter.
package triangle_wave_analyzer_pkg;

    // Direction of one sample-to-sample step
    typedef enum logic [1:0] {
        StepNone,
        StepUp,
        StepDown
    } step_e;

    // Analyzer tracking states
    typedef enum logic [1:0] {
        StSeek,
        StDir,
        StRise,
        StFall
    } ana_state_e;

    localparam int unsigned ErrCntW = 8;

endpackage

// File: rtl/triangle_wave_analyzer_sat_counter.sv
// Saturating up-counter used for the period measurement and the error count.
// Ports:
//   clk, rst_n  clock, async active-low reset (q returns to 0)
//   clear       synchronous clear to 0 (highest priority)
//   load1       synchronous load of 1 (second priority)
//   inc         increment by one, holds at all-ones
//   q           count value
//   sat         high while q is all-ones
module triangle_wave_analyzer_sat_counter
    import triangle_wave_analyzer_pkg::*;
#(
    parameter int unsigned WIDTH_P = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               load1,
    input  logic               inc,
    output logic [WIDTH_P-1:0] q,
    output logic               sat
);

    logic [WIDTH_P-1:0] cnt_q, cnt_d;

    assign sat = &cnt_q;
    assign q   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load1) begin
            cnt_d = WIDTH_P'(1);
        end else if (inc && !sat) begin
            cnt_d = cnt_q + WIDTH_P'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/triangle_wave_analyzer.sv
// Receive-side checker for a triangle modulation stream.
// Tracks slope on enabled samples, reports low peak, high peak and period at every low
// turnaround once a full cycle has been seen, asserts locked once reports repeat, and
// pulses step_err on any step that is not +/-1 without wrap.
// Optional feature macro: TRI_ANALYZER_ERRCNT_EN adds the saturating err_count port.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   enable      sample qualifier for mod_in
//   mod_in      triangle sample
//   low_out     last measured low peak
//   high_out    last measured high peak
//   period_out  samples between consecutive low peaks
//   valid       one-cycle pulse when the three measurements update
//   locked      measurements stable
//   step_err    one-cycle pulse on an illegal step
//   err_count   saturating count of step errors (feature macro only)
module triangle_wave_analyzer
    import triangle_wave_analyzer_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PERIOD_W   = 16,
    parameter int unsigned LOCK_COUNT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [WIDTH-1:0]    mod_in,
    output logic [WIDTH-1:0]    low_out,
    output logic [WIDTH-1:0]    high_out,
    output logic [PERIOD_W-1:0] period_out,
    output logic                valid,
    output logic                locked,
    output logic                step_err
`ifdef TRI_ANALYZER_ERRCNT_EN
    ,
    output logic [ErrCntW-1:0]  err_count
`endif
);

    localparam logic [WIDTH-1:0] One     = WIDTH'(1);
    localparam logic [7:0]       LockCnt = 8'(LOCK_COUNT);

    ana_state_e          state_q, state_d;
    logic [WIDTH-1:0]    prev_q;
    logic [WIDTH-1:0]    high_peak_q, high_peak_d;
    logic                seen_high_q, seen_high_d;
    logic                seen_low_q, seen_low_d;
    logic                enable_q;
    logic [WIDTH-1:0]    low_q, high_q;
    logic [PERIOD_W-1:0] period_q;
    logic                valid_q, step_err_q;
    logic [7:0]          match_q, match_d;

    logic                sync, err, low_peak, report, same;
    step_e               step;
    logic [PERIOD_W-1:0] pcnt;
    logic                pcnt_sat;

    // First accepted sample after enable rises restarts tracking without an error
    assign sync = enable && !enable_q;

    // Wrap-around steps are deliberately excluded by the carry/borrow guards
    always_comb begin
        step = StepNone;
        if (prev_q != '1 && mod_in == prev_q + One) begin
            step = StepUp;
        end else if (prev_q != '0 && mod_in == prev_q - One) begin
            step = StepDown;
        end
    end

    always_comb begin
        state_d     = state_q;
        high_peak_d = high_peak_q;
        seen_high_d = seen_high_q;
        seen_low_d  = seen_low_q;
        err         = 1'b0;
        low_peak    = 1'b0;
        if (enable) begin
            if (sync) begin
                state_d     = StDir;
                seen_high_d = 1'b0;
                seen_low_d  = 1'b0;
            end else begin
                unique case (state_q)
                    StSeek: state_d = StDir;
                    StDir: begin
                        if (step == StepUp) begin
                            state_d = StRise;
                        end else if (step == StepDown) begin
                            state_d = StFall;
                        end else begin
                            err = 1'b1;
                        end
                    end
                    StRise: begin
                        if (step == StepDown) begin
                            high_peak_d = prev_q;
                            seen_high_d = 1'b1;
                            state_d     = StFall;
                        end else if (step != StepUp) begin
                            err = 1'b1;
                        end
                    end
                    StFall: begin
                        if (step == StepUp) begin
                            low_peak   = 1'b1;
                            seen_low_d = 1'b1;
                            state_d    = StRise;
                        end else if (step != StepDown) begin
                            err = 1'b1;
                        end
                    end
                endcase
                if (err) begin
                    state_d     = StSeek;
                    seen_high_d = 1'b0;
                    seen_low_d  = 1'b0;
                end
            end
        end
    end

    // Report needs a full cycle: a high peak and an earlier low peak since resync
    assign report = low_peak && seen_high_q && seen_low_q;

    // A saturated period is not a measurement, so it can never count towards lock
    assign same = (prev_q == low_q) && (high_peak_q == high_q) && (pcnt == period_q)
                  && !pcnt_sat;

    always_comb begin
        match_d = match_q;
        if (err) begin
            match_d = '0;
        end else if (report) begin
            if (!same) begin
                match_d = '0;
            end else if (match_q < LockCnt) begin
                match_d = match_q + 8'd1;
            end
        end
    end

    // Counts samples since the last low peak; the peak-detecting sample starts at 1
    triangle_wave_analyzer_sat_counter #(
        .WIDTH_P (PERIOD_W)
    ) u_period_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (sync),
        .load1 (low_peak),
        .inc   (enable),
        .q     (pcnt),
        .sat   (pcnt_sat)
    );

`ifdef TRI_ANALYZER_ERRCNT_EN
    logic err_sat;

    triangle_wave_analyzer_sat_counter #(
        .WIDTH_P (ErrCntW)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (1'b0),
        .load1 (1'b0),
        .inc   (err && !err_sat),
        .q     (err_count),
        .sat   (err_sat)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StSeek;
            prev_q      <= '0;
            high_peak_q <= '0;
            seen_high_q <= 1'b0;
            seen_low_q  <= 1'b0;
            enable_q    <= 1'b0;
            low_q       <= '0;
            high_q      <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            step_err_q  <= 1'b0;
            match_q     <= '0;
        end else begin
            enable_q    <= enable;
            state_q     <= state_d;
            high_peak_q <= high_peak_d;
            seen_high_q <= seen_high_d;
            seen_low_q  <= seen_low_d;
            valid_q     <= report;
            step_err_q  <= err;
            match_q     <= match_d;
            if (enable) begin
                prev_q <= mod_in;
            end
            if (report) begin
                low_q    <= prev_q;
                high_q   <= high_peak_q;
                period_q <= pcnt;
            end
        end
    end

    assign low_out    = low_q;
    assign high_out   = high_q;
    assign period_out = period_q;
    assign valid      = valid_q;
    assign step_err   = step_err_q;
    assign locked     = (match_q >= LockCnt);

endmodule

// File: tb/tb_triangle_wave_analyzer.sv
`timescale 1ns/1ps
module tb_triangle_wave_analyzer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0, enable4 = 1'b0;
    logic [7:0]  mod_in = '0, mod_in4 = '0;
    logic [7:0]  low_out, high_out, low_out4, high_out4;
    logic [15:0] period_out;
    logic [3:0]  period_out4;
    logic        valid, locked, step_err, valid4, locked4, step_err4;
`ifdef TRI_ANALYZER_ERRCNT_EN
    logic [7:0]  err_count, err_count4;
`endif

    always #5 clk = ~clk;

    triangle_wave_analyzer #(
        .WIDTH      (8),
        .PERIOD_W   (16),
        .LOCK_COUNT (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .mod_in     (mod_in),
        .low_out    (low_out),
        .high_out   (high_out),
        .period_out (period_out),
        .valid      (valid),
        .locked     (locked),
        .step_err   (step_err)
`ifdef TRI_ANALYZER_ERRCNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    triangle_wave_analyzer #(
        .WIDTH      (8),
        .PERIOD_W   (4),
        .LOCK_COUNT (2)
    ) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable4),
        .mod_in     (mod_in4),
        .low_out    (low_out4),
        .high_out   (high_out4),
        .period_out (period_out4),
        .valid      (valid4),
        .locked     (locked4),
        .step_err   (step_err4)
`ifdef TRI_ANALYZER_ERRCNT_EN
        ,
        .err_count  (err_count4)
`endif
    );

    typedef struct packed {
        logic        v;
        logic        e;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] per;
        logic        lk;
    } ev_t;

    ev_t exp_q[$];
    ev_t exp4_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // Generator model
    int g_val, g_lo, g_hi;
    bit g_up;

    task automatic gen_reload(input int lo, input int hi);
        g_lo = lo; g_hi = hi; g_val = lo; g_up = 1'b1;
    endtask

    task automatic gen_next(output logic [7:0] v);
        v = 8'(g_val);
        if (g_up) begin
            if (g_val >= g_hi) begin g_up = 1'b0; g_val--; end
            else g_val++;
        end else begin
            if (g_val <= g_lo) begin g_up = 1'b1; g_val++; end
            else g_val--;
        end
    endtask

    task automatic drive_gen(input int n, input bit aux);
        logic [7:0] v;
        for (int i = 0; i < n; i++) begin
            gen_next(v);
            @(negedge clk);
            if (aux) begin enable4 = 1'b1; mod_in4 = v; end
            else begin enable = 1'b1; mod_in = v; end
        end
    endtask

    task automatic drive_raw(input logic [7:0] v);
        @(negedge clk);
        enable = 1'b1;
        mod_in = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            enable  = 1'b0;
            enable4 = 1'b0;
        end
    endtask

    task automatic exp_rep(input int lo, input int hi, input int per, input bit lk);
        ev_t ev;
        ev = '{v: 1'b1, e: 1'b0, lo: 8'(lo), hi: 8'(hi), per: 16'(per), lk: lk};
        exp_q.push_back(ev);
    endtask

    task automatic exp_err();
        ev_t ev;
        ev = '{v: 1'b0, e: 1'b1, lo: 8'd0, hi: 8'd0, per: 16'd0, lk: 1'b0};
        exp_q.push_back(ev);
    endtask

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor for the main instance
    always @(negedge clk) begin
        if (rst_n && (valid || step_err)) begin
            ev_t ex;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL main_event: got valid=%0b step_err=%0b low=%0d high=%0d per=%0d, required no event",
                         valid, step_err, low_out, high_out, period_out);
            end else begin
                ex = exp_q.pop_front();
                if (valid !== ex.v || step_err !== ex.e || locked !== ex.lk ||
                    (ex.v && (low_out !== ex.lo || high_out !== ex.hi || period_out !== ex.per))) begin
                    n_bad++;
                    $display("FAIL main_event: got v=%0b e=%0b lo=%0d hi=%0d per=%0d lk=%0b, required v=%0b e=%0b lo=%0d hi=%0d per=%0d lk=%0b",
                             valid, step_err, low_out, high_out, period_out, locked,
                             ex.v, ex.e, ex.lo, ex.hi, ex.per, ex.lk);
                end
            end
        end
    end

    // Monitor for the narrow-period instance
    always @(negedge clk) begin
        if (rst_n && (valid4 || step_err4)) begin
            ev_t ex;
            n_cmp++;
            if (exp4_q.size() == 0) begin
                n_bad++;
                $display("FAIL p4_event: got valid=%0b step_err=%0b, required no event", valid4, step_err4);
            end else begin
                ex = exp4_q.pop_front();
                if (valid4 !== ex.v || step_err4 !== ex.e || locked4 !== ex.lk ||
                    low_out4 !== ex.lo || high_out4 !== ex.hi || {12'd0, period_out4} !== ex.per) begin
                    n_bad++;
                    $display("FAIL p4_event: got v=%0b e=%0b lo=%0d hi=%0d per=%0d lk=%0b, required v=%0b e=%0b lo=%0d hi=%0d per=%0d lk=%0b",
                             valid4, step_err4, low_out4, high_out4, period_out4, locked4,
                             ex.v, ex.e, ex.lo, ex.hi, ex.per, ex.lk);
                end
            end
        end
    end

    initial begin
        // Reset state
        #12;
        chk("rst_low", low_out, 0);
        chk("rst_high", high_out, 0);
        chk("rst_period", period_out, 0);
        chk("rst_valid", valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_step_err", step_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        // Clean 10..20 wave: reports from the 2nd detected low peak, lock on the 3rd
        gen_reload(10, 20);
        exp_rep(10, 20, 20, 0);
        exp_rep(10, 20, 20, 0);
        exp_rep(10, 20, 20, 1);
        drive_gen(82, 1'b0);

        // High limit moves to 30 mid-rise
        g_hi = 30;
        exp_rep(10, 30, 40, 0);
        exp_rep(10, 30, 40, 0);
        exp_rep(10, 30, 40, 1);
        drive_gen(120, 1'b0);

        // Jump 15->17 mid-rise, then two fresh low peaks before the next report
        exp_err();
        drive_gen(4, 1'b0);
        drive_raw(8'd17);
        g_val = 18;
        g_up  = 1'b1;
        exp_rep(10, 30, 40, 0);
        drive_gen(74, 1'b0);
        idle(3);
        chk("q_empty_jump", exp_q.size(), 0);
`ifdef TRI_ANALYZER_ERRCNT_EN
        chk("err_count_1", err_count, 1);
`endif

        // Held sample, wrap up 255->0, wrap down 0->255
        exp_err();
        exp_err();
        exp_err();
        drive_gen(4, 1'b0);
        drive_raw(8'd15);
        for (int v = 250; v <= 255; v++) drive_raw(8'(v));
        drive_raw(8'd0);
        drive_raw(8'd1);
        drive_raw(8'd0);
        drive_raw(8'd255);
        idle(3);
        chk("q_empty_wrap", exp_q.size(), 0);
`ifdef TRI_ANALYZER_ERRCNT_EN
        chk("err_count_4", err_count, 4);
`endif

        // Enable dropped mid-fall: generator reloads, no error, lock survives
        gen_reload(10, 20);
        exp_rep(10, 20, 20, 0);
        exp_rep(10, 20, 20, 0);
        exp_rep(10, 20, 20, 1);
        drive_gen(82, 1'b0);
        drive_gen(12, 1'b0);
        idle(5);
        gen_reload(10, 20);
        exp_rep(10, 20, 20, 1);
        exp_rep(10, 20, 20, 1);
        exp_rep(10, 20, 20, 1);
        drive_gen(82, 1'b0);

        // Async reset mid-rise
        drive_gen(4, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_low", low_out, 0);
        chk("arst_high", high_out, 0);
        chk("arst_period", period_out, 0);
        chk("arst_locked", locked, 0);
        chk("arst_valid", valid, 0);
        chk("arst_step_err", step_err, 0);
        chk("q_empty_arst", exp_q.size(), 0);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // Minimal wave 0..1
        gen_reload(0, 1);
        exp_rep(0, 1, 2, 0);
        exp_rep(0, 1, 2, 0);
        exp_rep(0, 1, 2, 1);
        drive_gen(10, 1'b0);
        idle(3);
        chk("q_empty_min", exp_q.size(), 0);

        // 4-bit period counter with a 40-sample wave saturates and never locks
        gen_reload(0, 20);
        for (int i = 0; i < 3; i++) begin
            ev_t ev;
            ev = '{v: 1'b1, e: 1'b0, lo: 8'd0, hi: 8'd20, per: 16'd15, lk: 1'b0};
            exp4_q.push_back(ev);
        end
        drive_gen(162, 1'b1);
        idle(3);
        chk("q_empty_p4", exp4_q.size(), 0);
        chk("p4_locked", locked4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
